// File: rtl/surf_sched_pkg.sv
// Shared constants and types for the trigger buffer scheduler: buffer and
// command-FSM state encodings plus the command FIFO entry layout.
package surf_sched_pkg;

   localparam int NBUF    = 4;
   localparam int BUF_W   = 2;
   localparam int EVID_W  = 32;
   localparam int DROP_W  = 16;
   localparam int ENTRY_W = EVID_W + BUF_W;

   typedef enum logic [1:0] {
      BUF_FREE    = 2'd0,
      BUF_QUEUED  = 2'd1,
      BUF_READOUT = 2'd2
   } buf_state_e;

   typedef enum logic [1:0] {
      FSM_IDLE  = 2'd0,
      FSM_ISSUE = 2'd1,
      FSM_WAIT  = 2'd2
   } fsm_state_e;

   typedef struct packed {
      logic [EVID_W-1:0] evid;
      logic [BUF_W-1:0]  idx;
   } cmd_entry_t;

endpackage

// File: rtl/sched_cmd_fifo.sv
// Small first-in first-out queue of pending readout commands. The head is
// presented combinationally so the command FSM can latch it on issue.
module sched_cmd_fifo import surf_sched_pkg::*; #(
   parameter int WIDTH = ENTRY_W,
   parameter int DEPTH = NBUF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);
   assign head_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/trigger_buffer_scheduler.sv
// Allocates one of four readout buffers per trigger, queues a command per
// allocation and sequences those commands to the serializer one at a time.
module trigger_buffer_scheduler import surf_sched_pkg::*; #(
   parameter logic [EVID_W-1:0] EVID_RESET   = 32'h0,
   parameter int                DONE_TIMEOUT = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              trig_i,
   input  logic              clear_i,
   input  logic [BUF_W-1:0]  clear_buf_i,
   input  logic              cmd_busy_i,
   input  logic              cmd_done_i,
   output logic              cmd_start_o,
   output logic [EVID_W-1:0] cmd_event_id_o,
   output logic [BUF_W-1:0]  cmd_buffer_o,
   output logic [NBUF-1:0]   hold_o,
   output logic              dead_o,
   output logic [EVID_W-1:0] event_count_o,
   output logic [DROP_W-1:0] drop_count_o,
   output logic              cmd_err_o
);

   localparam int               TMR_W    = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DONE_TIMEOUT - 1);

   logic [NBUF-1:0]   free_vec;
   logic              alloc_found, accept;
   logic [BUF_W-1:0]  alloc_idx;
   logic [BUF_W-1:0]  alloc_ptr_q, alloc_ptr_d;
   logic [EVID_W-1:0] evid_q, evid_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   fsm_state_e        fsm_q, fsm_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [EVID_W-1:0] cmd_id_q, cmd_id_d;
   logic [BUF_W-1:0]  cmd_buf_q, cmd_buf_d;
   logic              err_q, err_d;
   logic              cmd_pop, cmd_complete;

   cmd_entry_t        push_entry, fifo_head;
   logic              fifo_empty;

   // Round-robin search over the registered FREE flags, starting at alloc_ptr.
   always_comb begin
      logic [BUF_W-1:0] cand;
      alloc_found = 1'b0;
      alloc_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NBUF; k++) begin
         cand = alloc_ptr_q + BUF_W'(k);
         if (!alloc_found && free_vec[cand]) begin
            alloc_found = 1'b1;
            alloc_idx   = cand;
         end
      end
   end

   assign accept     = trig_i && alloc_found;
   assign push_entry = {evid_q, alloc_idx};

   always_comb begin
      alloc_ptr_d = alloc_ptr_q;
      evid_d      = evid_q;
      drop_d      = drop_q;
      if (accept) begin
         alloc_ptr_d = alloc_idx + BUF_W'(1);
         evid_d      = evid_q + EVID_W'(1);
      end else if (trig_i && (drop_q != '1)) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alloc_ptr_q <= '0;
         evid_q      <= EVID_RESET;
         drop_q      <= '0;
      end else begin
         alloc_ptr_q <= alloc_ptr_d;
         evid_q      <= evid_d;
         drop_q      <= drop_d;
      end
   end

   // The three transitions always target buffers in distinct states, so at
   // most one of them applies to any given buffer in a cycle.
   for (genvar gi = 0; gi < NBUF; gi++) begin : gen_buf
      buf_state_e st_q, st_d;

      always_comb begin
         st_d = st_q;
         if (accept && (alloc_idx == BUF_W'(gi))) begin
            st_d = BUF_QUEUED;
         end
         if (clear_i && (clear_buf_i == BUF_W'(gi)) && (st_q == BUF_READOUT)) begin
            st_d = BUF_FREE;
         end
         if (cmd_complete && (cmd_buf_q == BUF_W'(gi))) begin
            st_d = BUF_READOUT;
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            st_q <= BUF_FREE;
         end else begin
            st_q <= st_d;
         end
      end

      assign free_vec[gi] = (st_q == BUF_FREE);
      assign hold_o[gi]   = (st_q != BUF_FREE);
   end

   assign dead_o = &hold_o;

   sched_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (NBUF)
   ) u_cmd_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (accept),
      .push_data_i (push_entry),
      .pop_i       (cmd_pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      fsm_d        = fsm_q;
      timer_d      = timer_q;
      cmd_id_d     = cmd_id_q;
      cmd_buf_d    = cmd_buf_q;
      err_d        = err_q;
      cmd_pop      = 1'b0;
      cmd_complete = 1'b0;
      case (fsm_q)
         FSM_IDLE: begin
            if (!fifo_empty && !cmd_busy_i) begin
               fsm_d     = FSM_ISSUE;
               cmd_id_d  = fifo_head.evid;
               cmd_buf_d = fifo_head.idx;
            end
         end
         FSM_ISSUE: begin
            fsm_d   = FSM_WAIT;
            timer_d = '0;
         end
         FSM_WAIT: begin
            // A done arriving on the last allowed cycle still counts as success.
            if (cmd_done_i) begin
               fsm_d        = FSM_IDLE;
               cmd_pop      = 1'b1;
               cmd_complete = 1'b1;
            end else if (timer_q == TMR_LAST) begin
               fsm_d        = FSM_IDLE;
               cmd_pop      = 1'b1;
               cmd_complete = 1'b1;
               err_d        = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: fsm_d = FSM_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fsm_q     <= FSM_IDLE;
         timer_q   <= '0;
         cmd_id_q  <= '0;
         cmd_buf_q <= '0;
         err_q     <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         timer_q   <= timer_d;
         cmd_id_q  <= cmd_id_d;
         cmd_buf_q <= cmd_buf_d;
         err_q     <= err_d;
      end
   end

   assign cmd_start_o    = (fsm_q == FSM_ISSUE);
   assign cmd_event_id_o = cmd_id_q;
   assign cmd_buffer_o   = cmd_buf_q;
   assign event_count_o  = evid_q;
   assign drop_count_o   = drop_q;
   assign cmd_err_o      = err_q;

endmodule

// File: tb/tb_trigger_buffer_scheduler.sv
// Scoreboard bench: a buffer-level reference model predicts commands and
// status; a negedge monitor pops predictions and plays the serializer.
module tb_trigger_buffer_scheduler;

   localparam int TIMEOUT   = 1024;
   localparam int M_FREE    = 0;
   localparam int M_QUEUED  = 1;
   localparam int M_READOUT = 2;

   logic        clk = 1'b0;
   logic        rst_i, trig_i, clear_i, cmd_busy_i, cmd_done_i;
   logic [1:0]  clear_buf_i;
   logic        cmd_start_o, dead_o, cmd_err_o;
   logic [31:0] cmd_event_id_o, event_count_o;
   logic [1:0]  cmd_buffer_o;
   logic [3:0]  hold_o;
   logic [15:0] drop_count_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state
   int          st [4];
   int          m_ptr;
   logic [31:0] m_ev;
   logic [15:0] m_drop;
   logic        m_err;
   bit          m_inflight;
   int          m_wait;
   logic [33:0] m_cur;
   logic [33:0] exp_q [$];
   logic [33:0] flight_q [$];

   // monitor / serializer state
   logic [33:0] obs_q [$];
   int          start_cnt = 0;
   int          last_start_cyc = 0;
   int          done_cnt = 0;
   bit          withhold = 0;
   bit          rand_mode = 0;

   trigger_buffer_scheduler #(
      .EVID_RESET   (32'h0),
      .DONE_TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .trig_i         (trig_i),
      .clear_i        (clear_i),
      .clear_buf_i    (clear_buf_i),
      .cmd_busy_i     (cmd_busy_i),
      .cmd_done_i     (cmd_done_i),
      .cmd_start_o    (cmd_start_o),
      .cmd_event_id_o (cmd_event_id_o),
      .cmd_buffer_o   (cmd_buffer_o),
      .hold_o         (hold_o),
      .dead_o         (dead_o),
      .event_count_o  (event_count_o),
      .drop_count_o   (drop_count_o),
      .cmd_err_o      (cmd_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 4; b++) st[b] = M_FREE;
      m_ptr = 0; m_ev = 32'h0; m_drop = 16'h0; m_err = 1'b0;
      m_inflight = 0; m_wait = 0; m_cur = '0;
      exp_q.delete();
      flight_q.delete();
   endtask

   task automatic model_step();
      int  ns [4];
      bit  got;
      int  ix;
      ns = st;
      if (trig_i) begin
         got = 0;
         for (int k = 0; k < 4; k++) begin
            ix = (m_ptr + k) % 4;
            if (!got && st[ix] == M_FREE) begin
               got = 1;
               ns[ix] = M_QUEUED;
               m_ptr = (ix + 1) % 4;
               exp_q.push_back({m_ev, 2'(ix)});
               m_ev = m_ev + 32'd1;
            end
         end
         if (!got && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      if (clear_i && st[clear_buf_i] == M_READOUT) ns[clear_buf_i] = M_FREE;
      if (m_inflight) begin
         if (cmd_done_i) begin
            ns[m_cur[1:0]] = M_READOUT;
            m_inflight = 0;
         end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
               ns[m_cur[1:0]] = M_READOUT;
               m_inflight = 0;
               m_err = 1'b1;
            end
         end
      end
      if (flight_q.size() > 0) begin
         m_cur = flight_q.pop_front();
         m_inflight = 1;
         m_wait = 0;
      end
      st = ns;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (rst_i) model_reset();
         else model_step();
      end
   end

   // monitor: status compare, command scoreboard, serializer done generation
   initial begin
      logic [3:0]  eh;
      logic [33:0] e;
      cmd_done_i = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            done_cnt   = 0;
            cmd_done_i = 1'b0;
         end else begin
            for (int b = 0; b < 4; b++) eh[b] = (st[b] != M_FREE);
            chk("hold", hold_o, eh);
            chk("dead", dead_o, &eh);
            chk("evcnt", event_count_o, m_ev);
            chk("drop", drop_count_o, m_drop);
            chk("err", cmd_err_o, m_err);
            cmd_done_i = 1'b0;
            if (done_cnt > 0) begin
               done_cnt--;
               if (done_cnt == 0) cmd_done_i = 1'b1;
            end
            if (cmd_start_o) begin
               chk("start_while_busy", m_inflight, 1'b0);
               obs_q.push_back({cmd_event_id_o, cmd_buffer_o});
               start_cnt++;
               last_start_cyc = cyc;
               if (exp_q.size() == 0) begin
                  chk("start_unexpected", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk("start_id", cmd_event_id_o, e[33:2]);
                  chk("start_buf", cmd_buffer_o, e[1:0]);
                  flight_q.push_back(e);
               end
               if (!withhold) done_cnt = rand_mode ? int'($urandom_range(1, 40)) : 20;
            end
            if (rand_mode && ($urandom % 50 == 0)) cmd_done_i = 1'b1;
            if (cmd_done_i && m_inflight) begin
               chk("held_id", cmd_event_id_o, m_cur[33:2]);
               chk("held_buf", cmd_buffer_o, m_cur[1:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rst_outputs(input string p);
      chk({p, "_hold"}, hold_o, 4'h0);
      chk({p, "_dead"}, dead_o, 1'b0);
      chk({p, "_evcnt"}, event_count_o, 32'h0);
      chk({p, "_drop"}, drop_count_o, 16'h0);
      chk({p, "_err"}, cmd_err_o, 1'b0);
      chk({p, "_start"}, cmd_start_o, 1'b0);
      chk({p, "_id"}, cmd_event_id_o, 32'h0);
      chk({p, "_buf"}, cmd_buffer_o, 2'h0);
   endtask

   task automatic do_reset(input string p);
      rst_i = 1'b1;
      #1;
      chk_rst_outputs(p);
      step();
      step();
      rst_i = 1'b0;
      step();
   endtask

   task automatic wait_starts(input int n, input string nm);
      int lim = 0;
      while (start_cnt < n && lim < 300) begin
         step();
         lim++;
      end
      chk(nm, start_cnt, n);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int lim = 0;
      while ((exp_q.size() != 0 || flight_q.size() != 0 || m_inflight) && lim < budget) begin
         step();
         lim++;
      end
      chk(nm, (lim < budget), 1'b1);
   endtask

   initial begin
      int n, base, s, lim;
      rst_i = 1'b1; trig_i = 1'b0; clear_i = 1'b0; clear_buf_i = 2'd0; cmd_busy_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_rst_outputs("por");
      rst_i = 1'b0;
      step();

      // single trigger
      trig_i = 1'b1; n = cyc; step(); trig_i = 1'b0;
      chk("single_hold", hold_o, 4'b0001);
      wait_starts(1, "single_start");
      chk("single_latency", last_start_cyc, n + 2);
      chk("single_cmd", obs_q[$], {32'd0, 2'd0});
      repeat (25) step();
      chk("single_readout_hold", hold_o, 4'b0001);
      clear_i = 1'b1; clear_buf_i = 2'd0; step(); clear_i = 1'b0;
      chk("single_cleared", hold_o, 4'b0000);

      // burst, then drops while dead
      do_reset("rst_burst");
      base = start_cnt;
      trig_i = 1'b1; repeat (4) step(); trig_i = 1'b0;
      chk("burst_hold", hold_o, 4'b1111);
      chk("burst_dead", dead_o, 1'b1);
      trig_i = 1'b1; repeat (2) step(); trig_i = 1'b0; step();
      chk("drop_count", drop_count_o, 16'd2);
      chk("drop_evcnt", event_count_o, 32'd4);
      wait_idle("burst_drain", 400);
      for (int i = 0; i < 4; i++) chk($sformatf("burst_cmd%0d", i), obs_q[base + i], {32'(i), 2'(i)});

      // round-robin after clearing 1 and 2
      clear_i = 1'b1; clear_buf_i = 2'd1; step();
      clear_buf_i = 2'd2; step(); clear_i = 1'b0;
      trig_i = 1'b1; step(); trig_i = 1'b0;
      chk("rr_hold", hold_o, 4'b1011);
      wait_idle("rr_drain", 100);
      chk("rr_cmd", obs_q[$], {32'd4, 2'd1});
      trig_i = 1'b1; step(); trig_i = 1'b0;
      chk("rr_dead", dead_o, 1'b1);
      wait_idle("rr2_drain", 100);
      chk("rr2_cmd", obs_q[$], {32'd5, 2'd2});
      // clear and trigger together: cleared buffer not yet allocatable
      clear_i = 1'b1; clear_buf_i = 2'd3; trig_i = 1'b1; step();
      clear_i = 1'b0; trig_i = 1'b0;
      chk("same_cycle_drop", drop_count_o, 16'd3);
      chk("same_cycle_hold", hold_o, 4'b0111);
      trig_i = 1'b1; step(); trig_i = 1'b0;
      wait_idle("same_cycle_drain", 100);
      chk("same_cycle_cmd", obs_q[$], {32'd6, 2'd3});

      // done timeout, then the next queued command issues
      do_reset("rst_tmo");
      base = start_cnt;
      withhold = 1;
      trig_i = 1'b1; repeat (2) step(); trig_i = 1'b0;
      wait_starts(base + 1, "tmo_first_start");
      s = last_start_cyc;
      lim = 0;
      while (!cmd_err_o && lim < 1200) begin
         step();
         lim++;
      end
      // start cycle, then 1024 WAIT cycles, flag visible the cycle after
      chk("tmo_cycles", cyc - s, 1025);
      withhold = 0;
      wait_starts(base + 2, "tmo_next_start");
      chk("tmo_next_cmd", obs_q[$], {32'd1, 2'd1});
      chk("tmo_err_sticky", cmd_err_o, 1'b1);
      repeat (3) step();

      // reset in WAIT
      do_reset("rst_mid");
      base = start_cnt;
      trig_i = 1'b1; step(); trig_i = 1'b0;
      wait_starts(base + 1, "post_rst_start");
      chk("post_rst_cmd", obs_q[$], {32'd0, 2'd0});
      wait_idle("post_rst_drain", 100);

      // randomized traffic against the model
      do_reset("rst_rand");
      rand_mode = 1;
      repeat (3000) begin
         trig_i      = ($urandom % 3 == 0);
         clear_i     = ($urandom % 3 == 0);
         clear_buf_i = 2'($urandom % 4);
         cmd_busy_i  = ($urandom % 5 == 0);
         step();
      end
      trig_i = 1'b0; cmd_busy_i = 1'b0; rand_mode = 0;
      lim = 0;
      while ((exp_q.size() != 0 || flight_q.size() != 0 || m_inflight || hold_o != 4'h0) && lim < 4000) begin
         clear_i = 1'b1;
         clear_buf_i = 2'(lim % 4);
         step();
         lim++;
      end
      clear_i = 1'b0;
      step();
      chk("rand_drained", (lim < 4000), 1'b1);
      chk("rand_final_hold", hold_o, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trigger_buffer_scheduler.md
TRIGGER_BUFFER_SCHEDULER -- requirements
Module: trigger_buffer_scheduler

Interface
REQ-001 Parameter EVID_RESET, 32'h0, first event ID issued after reset.
REQ-002 Parameter DONE_TIMEOUT, 1024, clk_i cycles allowed in WAIT before abort.
REQ-003 clk_i  in  1  sole clock; all logic rising-edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 trig_i  in  1  single-cycle trigger pulse.
REQ-006 clear_i  in  1  single-cycle request to free the buffer on clear_buf_i.
REQ-007 clear_buf_i  in  2  buffer index to free.
REQ-008 cmd_busy_i  in  1  busy from the command serializer.
REQ-009 cmd_done_i  in  1  single-cycle done from the command serializer.
REQ-010 cmd_start_o  out  1  single-cycle start to the command serializer.
REQ-011 cmd_event_id_o  out  32  event ID of the command in flight; held stable from start until done.
REQ-012 cmd_buffer_o  out  2  buffer index of the command in flight; held like cmd_event_id_o.
REQ-013 hold_o  out  4  per-buffer hold, high while the buffer is not FREE.
REQ-014 dead_o  out  1  high when all four buffers are non-FREE.
REQ-015 event_count_o  out  32  next event ID to be assigned.
REQ-016 drop_count_o  out  16  triggers rejected while dead; saturates at 16'hFFFF.
REQ-017 cmd_err_o  out  1  sticky flag, set on done timeout.

Function
REQ-018 Each buffer SHALL hold a registered state: FREE, QUEUED (held, command pending or sending), or READOUT (command done, awaiting clear).
REQ-019 On trig_i with at least one FREE buffer, the scheduler SHALL allocate the first FREE buffer at or after alloc_ptr, searching modulo 4.
  - Allocated buffer goes to QUEUED.
  - alloc_ptr moves to the allocated index + 1 (mod 4).
  - Entry {event_count, index} is pushed to the command FIFO.
  - event_count increments with wrap at 2^32.
REQ-020 The allocation search SHALL use state registers as of the start of the trigger cycle.
REQ-021 hold_o[b] SHALL rise in cycle N+1 for trig_i in cycle N.
REQ-022 On trig_i with no FREE buffer, the scheduler SHALL leave state and event_count unchanged and increment drop_count_o (saturating).
REQ-023 The command FIFO SHALL be 4 entries deep and first-in first-out.
  - It cannot overflow, since the QUEUED count is at most 4.
  - A push and a pop in the same cycle SHALL both take effect.
REQ-024 The command FSM SHALL use states IDLE, ISSUE and WAIT:
  - IDLE->ISSUE when FIFO non-empty and cmd_busy_i=0; the FIFO head drives cmd_event_id_o and cmd_buffer_o.
  - ISSUE: cmd_start_o=1 for exactly one cycle, then ->WAIT.
  - WAIT->IDLE on cmd_done_i: pop FIFO; the head buffer goes QUEUED->READOUT.
  - WAIT->IDLE when the timer reaches DONE_TIMEOUT: pop FIFO, set cmd_err_o, and move the head buffer to READOUT.
REQ-025 The earliest cmd_start_o SHALL be cycle N+2 after an accepted trig_i in cycle N with the FSM idle.
REQ-026 clear_i SHALL move buffer clear_buf_i READOUT->FREE in the next cycle; clear_i on a FREE or QUEUED buffer SHALL be ignored.
REQ-027 For clear_i and trig_i in the same cycle, the cleared buffer SHALL NOT be allocated in that cycle; it SHALL be allocatable from the following cycle.
REQ-028 dead_o and hold_o SHALL be decoded directly from the state registers, with no extra pipeline stage.
REQ-029 cmd_done_i outside WAIT SHALL be ignored.

Reset
REQ-030 On rst_i, the block SHALL force immediately, mid-command included:
  - all buffers FREE and alloc_ptr=0;
  - FIFO empty and FSM in IDLE;
  - event_count=EVID_RESET;
  - drop_count=0 and cmd_err_o=0;
  - cmd_start_o=0, cmd_event_id_o=0 and cmd_buffer_o=0.

Structure
REQ-031 Package surf_sched_pkg SHALL hold NBUF=4, the buffer-state enum, the FSM-state enum, EVID_W=32 and DROP_W=16.
REQ-032 The command FIFO SHALL be a sub-module sched_cmd_fifo with a 34-bit width and a depth of 4.

Verification
REQ-033 Single trigger:
  - Stimulus: reset, then trig_i; model completes with cmd_done_i 20 cycles after start.
  - Response: hold_o=0001; one start with event ID 0 and buffer 0; state READOUT; clear_i with buffer 0 gives hold_o=0000.
REQ-034 Burst:
  - Stimulus: four trig_i on consecutive cycles, no clears.
  - Response: hold_o=1111; dead_o=1; commands in order IDs 0,1,2,3 with buffers 0,1,2,3.
REQ-035 Dead-time drop:
  - Stimulus: two further trig_i while dead.
  - Response: drop_count_o=2; event_count_o stays 4.
REQ-036 Round-robin:
  - Stimulus: after REQ-034, clear buffers 1 and 2, then trig_i.
  - Response: buffer 1 allocated with ID 4 (alloc_ptr was 0 and buffer 0 is held, so the search finds 1).
REQ-037 Timeout:
  - Stimulus: cmd_done_i withheld.
  - Response: after 1024 cycles cmd_err_o=1; the next queued command issues.
REQ-038 Mid-command reset:
  - Stimulus: rst_i asserted in WAIT.
  - Response: all outputs at reset values the same cycle; the next trigger gets ID EVID_RESET and buffer 0.
